// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg
// Shared definitions for the gate result checker:
//   - run-control state encoding
//   - bit positions of the 5-bit fail record {a, b, and, or, xor}
//   - reference function for the expected AND/OR/XOR outputs
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int REC_W   = 5;
    localparam int FLD_A   = 4;
    localparam int FLD_B   = 3;
    localparam int FLD_AND = 2;
    localparam int FLD_OR  = 1;
    localparam int FLD_XOR = 0;

    // Returns {and, or, xor} for the applied inputs.
    function automatic logic [2:0] gate_expected(input logic a, input logic b);
        return {a & b, a | b, a ^ b};
    endfunction

endpackage

// File: rtl/gate_chk_fifo.sv
// gate_chk_fifo
// Synchronous first-word-fall-through FIFO holding failing vectors.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr           synchronous flush (empties the FIFO, overrides push/pop)
//   wr_en/wr_data push request and data; dropped when full unless popping
//   rd_en         pop request; ignored when empty
//   rd_data       head entry, valid whenever empty = 0
//   full, empty   occupancy flags
module gate_chk_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_rd;
    logic        do_wr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted when it coincides with a read.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !clr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/gate_result_checker.sv
// gate_result_checker
// Sink-side checker for the two-input gate block. Accepts sampled vectors
// {a, b, and, or, xor} over valid/ready, recomputes the expected outputs one
// cycle later, counts passes/fails and keeps failing vectors in a FIFO.
//
// Optional build macro: GATE_CHK_HIST_EN adds hist_cnt, per-{a,b} counts of
// accepted vectors packed {cnt11, cnt10, cnt01, cnt00}.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, num_vec           begin a run of num_vec vectors (IDLE/DONE only)
//   in_valid, in_ready       sample handshake
//   in_a, in_b               applied gate inputs
//   in_and, in_or, in_xor    observed gate outputs
//   busy, done               run status
//   pass_cnt, fail_cnt, err  results (saturating counters, sticky error)
//   fail_rd, fail_data,
//   fail_empty, fail_ovf     failing-vector FIFO readback and overflow flag
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting samples until num_vec have been taken
// DRAIN | no new samples; last accepted sample is being compared
// DONE  | results stable, done high, waiting for start
module gate_result_checker
    import gate_chk_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int FAIL_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_and,
    input  logic             in_or,
    input  logic             in_xor,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    input  logic             fail_rd,
    output logic [4:0]       fail_data,
    output logic             fail_empty,
    output logic             fail_ovf
`ifdef GATE_CHK_HIST_EN
    ,
    output logic [4*CNT_W-1:0] hist_cnt
`endif
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             start_ok;
    logic             accept;

    logic             cmp_vld;
    logic             cmp_a;
    logic             cmp_b;
    logic [2:0]       cmp_obs;
    logic [2:0]       cmp_exp;
    logic             cmp_fail;
    logic [REC_W-1:0] cmp_rec;

    logic             fifo_full;
    logic             fifo_push;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign accept   = in_valid && in_ready;

    // Run control. in_ready/busy/done are registered alongside the state so
    // they change on the same edge as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        remaining <= num_vec;
                        if (num_vec == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RUN;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (remaining == CNT_W'(1)) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Compare stage: one register between acceptance and checking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_vld <= 1'b0;
            cmp_a   <= 1'b0;
            cmp_b   <= 1'b0;
            cmp_obs <= '0;
        end else begin
            cmp_vld <= accept;
            if (accept) begin
                cmp_a   <= in_a;
                cmp_b   <= in_b;
                cmp_obs <= {in_and, in_or, in_xor};
            end
        end
    end

    // Case inequality so an X/Z on any observed output is a failure.
    always_comb begin
        cmp_exp  = gate_expected(cmp_a, cmp_b);
        cmp_fail = (cmp_obs !== cmp_exp);
        cmp_rec          = '0;
        cmp_rec[FLD_A]   = cmp_a;
        cmp_rec[FLD_B]   = cmp_b;
        cmp_rec[FLD_AND] = cmp_obs[2];
        cmp_rec[FLD_OR]  = cmp_obs[1];
        cmp_rec[FLD_XOR] = cmp_obs[0];
    end

    assign fifo_push = cmp_vld && cmp_fail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
            fail_ovf <= 1'b0;
        end else if (start_ok) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
            fail_ovf <= 1'b0;
        end else if (cmp_vld) begin
            if (cmp_fail) begin
                fail_cnt <= sat_inc(fail_cnt);
                err      <= 1'b1;
                // A full FIFO never reads as empty, so fail_rd alone tells
                // whether a slot frees up this cycle.
                if (fifo_full && !fail_rd) begin
                    fail_ovf <= 1'b1;
                end
            end else begin
                pass_cnt <= sat_inc(pass_cnt);
            end
        end
    end

    gate_chk_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FAIL_DEPTH)
    ) u_fail_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .wr_en   (fifo_push),
        .wr_data (cmp_rec),
        .rd_en   (fail_rd),
        .rd_data (fail_data),
        .full    (fifo_full),
        .empty   (fail_empty)
    );

`ifdef GATE_CHK_HIST_EN
    logic [CNT_W-1:0] hist_q [4];
    logic [1:0]       hist_idx;

    assign hist_idx = {cmp_a, cmp_b};
    assign hist_cnt = {hist_q[3], hist_q[2], hist_q[1], hist_q[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
        end else if (start_ok) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
        end else if (cmp_vld) begin
            hist_q[hist_idx] <= sat_inc(hist_q[hist_idx]);
        end
    end
`endif

endmodule

// File: tb/tb_gate_result_checker.sv
module tb_gate_result_checker;

    localparam int CNT_W      = 16;
    localparam int FAIL_DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vec = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_a = 1'b0, in_b = 1'b0;
    logic             in_and = 1'b0, in_or = 1'b0, in_xor = 1'b0;
    logic             busy, done, err;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    logic             fail_rd = 1'b0;
    logic [4:0]       fail_data;
    logic             fail_empty, fail_ovf;
`ifdef GATE_CHK_HIST_EN
    logic [4*CNT_W-1:0] hist_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: results of the current run.
    int         m_pass;
    int         m_fail;
    logic       m_err;
    logic       m_ovf;
    logic [4:0] m_q [$];

    always #5 clk = ~clk;

    gate_result_checker #(
        .CNT_W      (CNT_W),
        .FAIL_DEPTH (FAIL_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_vec    (num_vec),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_and     (in_and),
        .in_or      (in_or),
        .in_xor     (in_xor),
        .busy       (busy),
        .done       (done),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .err        (err),
        .fail_rd    (fail_rd),
        .fail_data  (fail_data),
        .fail_empty (fail_empty),
        .fail_ovf   (fail_ovf)
`ifdef GATE_CHK_HIST_EN
        ,
        .hist_cnt   (hist_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_pass = 0;
        m_fail = 0;
        m_err  = 1'b0;
        m_ovf  = 1'b0;
        m_q.delete();
    endtask

    // A vector passes when the observed outputs equal AND/OR/XOR of the inputs.
    task automatic model_apply(input logic a, input logic b, input logic [2:0] obs);
        logic [2:0] want;
        want = {a & b, a | b, a ^ b};
        if (obs === want) begin
            m_pass++;
        end else begin
            m_fail++;
            m_err = 1'b1;
            if (m_q.size() < FAIL_DEPTH) m_q.push_back({a, b, obs});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic start_run(input int n);
        start   = 1'b1;
        num_vec = CNT_W'(n);
        tick();
        start = 1'b0;
        model_clear();
    endtask

    task automatic send(input logic a, input logic b, input logic [2:0] obs, input int gap);
        for (int i = 0; i < gap; i++) tick();
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        {in_and, in_or, in_xor} = obs;
        for (int n = 0; n < 20 && !in_ready; n++) tick();
        chk("in_ready_wait", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        model_apply(a, b, obs);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 50 && !done; n++) tick();
        chk("done_wait", 64'(done), 64'(1));
    endtask

    task automatic check_results(input string tag);
        chk({tag, ".pass_cnt"}, 64'(pass_cnt), 64'(m_pass));
        chk({tag, ".fail_cnt"}, 64'(fail_cnt), 64'(m_fail));
        chk({tag, ".err"}, 64'(err), 64'(m_err));
        chk({tag, ".fail_ovf"}, 64'(fail_ovf), 64'(m_ovf));
        chk({tag, ".fail_empty"}, 64'(fail_empty), 64'(m_q.size() == 0));
        chk({tag, ".busy"}, 64'(busy), 64'(0));
    endtask

    task automatic pop_check(input string tag);
        chk({tag, ".fail_data"}, 64'(fail_data), 64'(m_q[0]));
        fail_rd = 1'b1;
        tick();
        fail_rd = 1'b0;
        void'(m_q.pop_front());
    endtask

    task automatic drain(input string tag);
        while (m_q.size() > 0) pop_check(tag);
        chk({tag, ".drained_empty"}, 64'(fail_empty), 64'(1));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".pass_cnt"}, 64'(pass_cnt), 64'(0));
        chk({tag, ".fail_cnt"}, 64'(fail_cnt), 64'(0));
        chk({tag, ".err"}, 64'(err), 64'(0));
        chk({tag, ".done"}, 64'(done), 64'(0));
        chk({tag, ".busy"}, 64'(busy), 64'(0));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, ".fail_empty"}, 64'(fail_empty), 64'(1));
        chk({tag, ".fail_ovf"}, 64'(fail_ovf), 64'(0));
`ifdef GATE_CHK_HIST_EN
        chk({tag, ".hist_cnt"}, hist_cnt, 64'(0));
`endif
    endtask

    initial begin
        logic       a, b;
        logic [2:0] good, obs;
        int         n;

        // Reset
        #1 rst = 1'b1;
        repeat (2) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // fail_rd while empty is ignored
        fail_rd = 1'b1;
        tick();
        fail_rd = 1'b0;
        chk("rd_empty.fail_empty", 64'(fail_empty), 64'(1));

        // All four combinations, correct outputs, back-to-back
        start_run(4);
        chk("t1.busy", 64'(busy), 64'(1));
        for (int i = 0; i < 4; i++) begin
            a = i[1];
            b = i[0];
            send(a, b, {a & b, a | b, a ^ b}, 0);
        end
        chk("t1.done_not_yet", 64'(done), 64'(0));
        tick();
        chk("t1.done_two_after", 64'(done), 64'(1));
        check_results("t1");
        chk("t1.pass4", 64'(pass_cnt), 64'(4));

        // Two failures, one pass; known FIFO records
        start_run(3);
        send(1'b1, 1'b1, 3'b010, 0);
        send(1'b0, 1'b1, 3'b011, 0);
        send(1'b0, 1'b0, 3'b001, 0);
        wait_done();
        check_results("t2");
        chk("t2.head0", 64'(fail_data), 64'(5'b11010));
        fail_rd = 1'b1;
        tick();
        fail_rd = 1'b0;
        chk("t2.head1", 64'(fail_data), 64'(5'b00001));
        fail_rd = 1'b1;
        tick();
        fail_rd = 1'b0;
        chk("t2.empty", 64'(fail_empty), 64'(1));

        // Ten failures, no pops: overflow, eight entries retained
        start_run(10);
        for (int i = 0; i < 10; i++) begin
            a = 1'($urandom);
            b = 1'($urandom);
            send(a, b, ~{a & b, a | b, a ^ b}, 0);
        end
        wait_done();
        check_results("t3");
        chk("t3.fail10", 64'(fail_cnt), 64'(10));
        chk("t3.ovf", 64'(fail_ovf), 64'(1));
        drain("t3");

        // Push and pop together while full: accepted, no overflow
        start_run(9);
        for (int i = 0; i < 8; i++) begin
            a = 1'($urandom);
            b = 1'($urandom);
            send(a, b, ~{a & b, a | b, a ^ b}, 0);
        end
        chk("t4.head", 64'(fail_data), 64'(m_q[0]));
        void'(m_q.pop_front());
        send(1'b1, 1'b0, 3'b111, 0);
        fail_rd = 1'b1;
        tick();
        fail_rd = 1'b0;
        wait_done();
        check_results("t4");
        drain("t4");

        // num_vec = 0
        start_run(0);
        chk("t5.done", 64'(done), 64'(1));
        chk("t5.in_ready", 64'(in_ready), 64'(0));
        chk("t5.busy", 64'(busy), 64'(0));
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        check_results("t5");

        // start during RUN is ignored; in_valid after DONE is ignored
        start_run(6);
        for (int i = 0; i < 3; i++) send(1'($urandom), 1'($urandom), 3'($urandom), 0);
        start   = 1'b1;
        num_vec = CNT_W'(2);
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) send(1'($urandom), 1'($urandom), 3'($urandom), 1);
        wait_done();
        check_results("t6");
        in_valid = 1'b1;
        in_a = 1'b1; in_b = 1'b1; {in_and, in_or, in_xor} = 3'b000;
        repeat (3) tick();
        chk("t6.in_ready_done", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        check_results("t6_post");
        drain("t6");

        // Asynchronous reset mid-run
        start_run(5);
        send(1'b1, 1'b1, 3'b000, 0);
        send(1'b0, 1'b0, 3'b111, 0);
        #2 rst = 1'b1;
        #1;
        check_reset_values("midrst");
        #2 rst = 1'b0;
        tick();
        start_run(4);
        for (int i = 0; i < 4; i++) send(1'($urandom), 1'($urandom), 3'($urandom), 0);
        wait_done();
        check_results("after_rst");
        drain("after_rst");

`ifdef GATE_CHK_HIST_EN
        start_run(6);
        send(1'b0, 1'b0, 3'b000, 0);
        send(1'b0, 1'b1, 3'b011, 0);
        send(1'b0, 1'b1, 3'b011, 0);
        send(1'b1, 1'b1, 3'b110, 0);
        send(1'b1, 1'b1, 3'b110, 0);
        send(1'b1, 1'b1, 3'b110, 0);
        wait_done();
        chk("hist", hist_cnt, {16'd3, 16'd0, 16'd2, 16'd1});
`endif

        // Randomized runs against the model
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 20));
            start_run(n);
            for (int i = 0; i < n; i++) begin
                a    = 1'($urandom);
                b    = 1'($urandom);
                good = {a & b, a | b, a ^ b};
                obs  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : good;
                send(a, b, obs, int'($urandom_range(0, 2)));
            end
            wait_done();
            check_results($sformatf("rand%0d", r));
            if (r % 2 == 0) drain($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gate_result_checker.md
Name: gate_result_checker

Overview:
- Sink-side checker for the two-input primitive gate block (outputs AND, OR, XOR). It sits at the opposite end from the stimulus driver.
- Accepts sampled vectors {a, b, and, or, xor} over a valid/ready handshake and recomputes the expected gate outputs.
- Counts passes and failures, and buffers failing vectors in a small FIFO for readback.
- A run covers a programmed number of vectors and is controlled by a small FSM.

Parameters:
- CNT_W, 16, width of the vector target and of the pass/fail counters.
- FAIL_DEPTH, 8, failing-vector FIFO depth; must be a power of 2, minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run; ignored unless state is IDLE or DONE.
- num_vec  in  CNT_W  number of vectors in the run; sampled on start.
- in_valid  in  1  sample valid.
- in_ready  out  1  checker can accept a sample.
- in_a, in_b  in  1 each  gate inputs that were applied.
- in_and, in_or, in_xor  in  1 each  observed gate outputs.
- busy  out  1  run in progress.
- done  out  1  run complete; held high until the next start.
- pass_cnt  out  CNT_W  number of matching vectors.
- fail_cnt  out  CNT_W  number of mismatching vectors.
- err  out  1  sticky flag, set on the first failure of a run.
- fail_rd  in  1  pop one entry from the fail FIFO.
- fail_data  out  5  head entry {a, b, and, or, xor}, first-word-fall-through.
- fail_empty  out  1  fail FIFO is empty.
- fail_ovf  out  1  sticky flag: a failing vector was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, active-high; effective immediately, including mid-run):
  - state = IDLE.
  - All counters = 0; err, done, busy, fail_ovf = 0.
  - FIFO empty; fail_empty = 1; in_ready = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE on start: latch num_vec; clear the counters, err, fail_ovf and FIFO; clear done.
    - If num_vec == 0, go to DONE; done is asserted the next cycle.
    - Otherwise go to RUN.
  - RUN: in_ready = 1. A transfer occurs when in_valid && in_ready. After the num_vec-th accepted transfer, go to DRAIN.
  - DRAIN: in_ready = 0. Wait one cycle for the compare stage, then go to DONE.
  - DONE: done = 1, busy = 0. The counters, err and FIFO contents hold.
- busy = 1 in RUN and DRAIN.
- Compare pipeline: one register stage.
  - Accepted sample at cycle N is compared at N+1; expected = {a&b, a|b, a^b}.
  - Counters, err and FIFO update at the edge ending cycle N+1, so they are visible at N+2.
  - Back-to-back transfers every cycle are supported (throughput 1/cycle).
- Any X/Z on an observed output counts as a fail, using case-inequality comparison.
- Counters saturate at 2^CNT_W−1. They never wrap.
- FIFO:
  - A failing vector is pushed when the FIFO is not full.
  - If the FIFO is full, the vector is dropped and fail_ovf is set; fail_cnt still increments.
  - fail_rd when empty is ignored.
  - A simultaneous push and pop when full is allowed: the entry is accepted, no overflow.
  - fail_rd is honoured in any state.
- start while in RUN or DRAIN is ignored.
- in_valid while in_ready = 0 is not a transfer; it has no effect on state or counters.

Optional Feature:
- Macro: GATE_CHK_HIST_EN.
- Defined:
  - Adds output hist_cnt (4×CNT_W, packed as {cnt11, cnt10, cnt01, cnt00}).
  - Each entry counts accepted vectors per {a, b} combination.
  - Entries saturate, clear on start and on reset, and update at the same edge as pass/fail.
- Not defined: the port and counters are absent.

Decomposition:
- Package gate_chk_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the 5-bit fail-record field order constants;
  - a function for expected outputs from (a, b).
- One sub-module: gate_chk_fifo, a synchronous FIFO with FWFT, full/empty and a clear input.

Test Plan:
- All 4 {a,b} combinations with correct outputs, num_vec=4, valid every cycle → pass_cnt=4, fail_cnt=0, err=0, done 2 cycles after the 4th accept, fail_empty=1.
- num_vec=3; vectors (1,1,and=0,or=1,xor=0), correct (0,1), (0,0,and=0,or=0,xor=1) → fail_cnt=2, pass_cnt=1, err=1; FIFO pops 5'b11010 then 5'b00001, then fail_empty=1.
- FAIL_DEPTH=8, 10 failing vectors, no pops → fail_cnt=10, fail_ovf=1, exactly 8 entries readable.
- start with num_vec=0 → DONE the next cycle, in_ready never asserted, counters 0.
- rst asserted mid-RUN after 2 accepts → all outputs at reset values immediately (asynchronously); a new start runs cleanly.
- GATE_CHK_HIST_EN defined, 6 vectors with {a,b} = 00,01,01,11,11,11 → hist_cnt = {3,0,2,1}.
